// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 keypad front end.
// KEYMAP is indexed by frame bit (row*COLS + col).
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KEYS = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_e;

    typedef enum logic [1:0] {
        FRAME_NONE,
        FRAME_SINGLE,
        FRAME_MULTI
    } frame_class_e;

    // Board layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    localparam logic [3:0] KEYMAP [KEYS] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/keypad_row_driver.sv
// Column synchronizer, scan divider and one-hot-low row rotation.
// Strobes mark the last cycle of each row slot and of each full frame.
module keypad_row_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COLS-1:0]         col_n,
    output logic [ROWS-1:0]         row_n,
    output logic [COLS-1:0]         col_sync,
    output logic                    sample,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    frame_end
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [COLS-1:0]  col_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
            div_cnt  <= '0;
            row_idx  <= '0;
            row_n    <= 4'b1110;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
            if (sample) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                row_n   <= {row_n[ROWS-2:0], row_n[ROWS-1]};
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Sampling on the slot's last cycle leaves the synchronizer time to settle after the row switch.
    assign sample    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = sample && (row_idx == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: builds a 16-bit frame per scan, classifies it and debounces
// single-key presses into one keyboard_en pulse per accepted key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 100_000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       keyboard_en,
    output logic [3:0] keyboard_num,
    output logic       key_down
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_FRAMES);

    logic [COLS-1:0]         col_sync;
    logic                    sample;
    logic [$clog2(ROWS)-1:0] row_idx;
    logic                    frame_end;

    keypad_row_driver #(.SCAN_DIV(SCAN_DIV)) u_row_driver (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .col_sync  (col_sync),
        .sample    (sample),
        .row_idx   (row_idx),
        .frame_end (frame_end)
    );

    logic [KEYS-1:0] frame;
    logic [KEYS-1:0] frame_now;
    logic [4:0]      n_bits;
    logic [3:0]      hit_idx;
    logic [3:0]      code;
    frame_class_e    cls;
    state_e          state;
    logic [3:0]      cnt;
    logic [3:0]      cand;

    // frame_now merges the row being sampled so classification sees the complete frame at frame_end.
    always_comb begin
        frame_now = frame;
        frame_now[{row_idx, 2'b00} +: COLS] = ~col_sync;
    end

    always_comb begin
        n_bits  = '0;
        hit_idx = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (frame_now[i]) begin
                n_bits  = n_bits + 5'd1;
                hit_idx = 4'(i);
            end
        end
        if (n_bits == 5'd0)      cls = FRAME_NONE;
        else if (n_bits == 5'd1) cls = FRAME_SINGLE;
        else                     cls = FRAME_MULTI;
        code = KEYMAP[hit_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
        end else if (sample) begin
            frame <= frame_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cand         <= '0;
            keyboard_en  <= 1'b0;
            keyboard_num <= 4'h0;
            key_down     <= 1'b0;
        end else begin
            keyboard_en <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (cls == FRAME_SINGLE) begin
                            cand <= code;
                            if (CNT_MAX == 4'd1) begin
                                state        <= HELD;
                                cnt          <= '0;
                                keyboard_en  <= 1'b1;
                                keyboard_num <= code;
                                key_down     <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (cls == FRAME_SINGLE && code == cand) begin
                            if (cnt + 4'd1 >= CNT_MAX) begin
                                state        <= HELD;
                                cnt          <= '0;
                                keyboard_en  <= 1'b1;
                                keyboard_num <= cand;
                                key_down     <= 1'b1;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    HELD: begin
                        // Extra keys or a continued hold never produce another event.
                        if (cls == FRAME_NONE) begin
                            if (CNT_MAX == 4'd1) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                key_down <= 1'b0;
                            end else begin
                                state <= RELEASE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    RELEASE: begin
                        if (cls == FRAME_NONE) begin
                            if (cnt + 4'd1 >= CNT_MAX) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                key_down <= 1'b0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= HELD;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
